// File: rtl/sg_compliance_monitor.sv
// State-graph compliance monitor: follows the spec state of an async circuit model
// through a loadable transition table and raises sticky compliance/persistency/stall flags.

// Per-signal persistency tracker: an enabled transition that disappears without firing.
module sg_pers_lane #(
  parameter bit EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic check,
  input  logic sig_b,
  input  logic precap_b,
  input  logic chg_b,
  output logic hit
);
  logic ena, ena_prev;

  assign ena = sig_b ^ precap_b;
  assign hit = EN & check & ena_prev & ~ena & ~chg_b;

  always_ff @(posedge clk or posedge reset)
    if (reset)      ena_prev <= 1'b0;
    else if (!arm)  ena_prev <= 1'b0;
    else if (check) ena_prev <= ena;
endmodule

module sg_compliance_monitor #(
  parameter int NSIG        = 4,
  parameter int NIN         = 2,
  parameter int NSTATE      = 8,
  parameter int INIT_STATE  = 0,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 16,
  localparam int SW   = (NSTATE > 1) ? $clog2(NSTATE) : 1,
  localparam int IW   = (NSIG > 1) ? $clog2(NSIG) : 1,
  localparam int NENT = NSTATE * NSIG * 2,
  localparam int AW   = $clog2(NENT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             clr_err,
  input  logic [NSIG-1:0]  sig,
  input  logic [NSIG-1:0]  sig_precap,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SW:0]      cfg_data,
  output logic [SW-1:0]    state,
  output logic             err_in,
  output logic             err_out,
  output logic             err_multi,
  output logic             err_pers,
  output logic             err_stall,
  output logic [NSIG-1:0]  pers_mask,
  output logic [2:0]       first_code,
  output logic [IW-1:0]    first_sig,
  output logic [SW-1:0]    first_state,
  output logic [CNT_W-1:0] viol_count,
  output logic [CNT_W-1:0] trans_count
);
  localparam int SCW = $clog2(STALL_LIMIT + 1);

  typedef struct packed {
    logic [2:0]    code;
    logic [IW-1:0] sidx;
    logic [SW-1:0] st;
  } err_rec_t;

  logic [NENT-1:0] tbl_vld;
  logic [SW-1:0]   tbl_nxt [NENT];
  logic            wr_en;

  logic [NSIG-1:0] sig_prev, chg, pers_hit;
  logic            primed, check, any_chg, multi, single, acc;
  logic [IW-1:0]   hot_idx, pers_idx;
  int              ent_i;
  logic [AW-1:0]   ent;
  logic            ent_ok;
  logic [SCW-1:0]  stall_cnt;
  logic            ev_in, ev_out, ev_multi, ev_pers, ev_stall, viol;
  err_rec_t        rec, rec_new;
  logic [CNT_W-1:0] vc_base, tc_base;

  // ---------------- transition table ----------------
  assign wr_en = cfg_we & ~arm & (32'(cfg_addr) < NENT);

  always_ff @(posedge clk or posedge reset)
    if (reset)      tbl_vld <= '0;
    else if (wr_en) tbl_vld[cfg_addr] <= cfg_data[SW];

  always_ff @(posedge clk)
    if (wr_en) tbl_nxt[cfg_addr] <= cfg_data[SW-1:0];

  // ---------------- change detection and lookup ----------------
  assign check   = arm & primed;
  assign chg     = sig ^ sig_prev;
  assign any_chg = |chg;
  assign multi   = (chg & (chg - NSIG'(1))) != '0;
  assign single  = any_chg & ~multi;

  always_comb begin
    hot_idx  = '0;
    pers_idx = '0;
    for (int k = NSIG - 1; k >= 0; k--) begin
      if (chg[k])      hot_idx  = IW'(k);
      if (pers_hit[k]) pers_idx = IW'(k);
    end
  end

  assign ent_i  = (32'(state) * NSIG + 32'(hot_idx)) * 2 + 32'(sig[hot_idx]);
  assign ent    = ent_i[AW-1:0];
  assign ent_ok = ent_i < NENT;
  assign acc    = check & single & ent_ok & tbl_vld[ent];

  for (genvar g = 0; g < NSIG; g++) begin : g_lane
    sg_pers_lane #(.EN(g >= NIN)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .arm      (arm),
      .check    (check),
      .sig_b    (sig[g]),
      .precap_b (sig_precap[g]),
      .chg_b    (chg[g]),
      .hit      (pers_hit[g])
    );
  end

  // ---------------- violation events ----------------
  assign ev_in    = check & single & ~acc & (32'(hot_idx) < NIN);
  assign ev_out   = check & single & ~acc & (32'(hot_idx) >= NIN);
  assign ev_multi = check & multi;
  assign ev_pers  = |pers_hit;
  assign ev_stall = check & ~any_chg & (stall_cnt == SCW'(STALL_LIMIT - 1));
  assign viol     = ev_in | ev_out | ev_multi | ev_pers | ev_stall;

  // lowest code wins when several fire together
  always_comb begin
    rec_new = '0;
    if (ev_in || ev_out) begin
      rec_new.code = ev_in ? 3'd1 : 3'd2;
      rec_new.sidx = hot_idx;
      rec_new.st   = state;
    end else if (ev_multi) begin
      rec_new.code = 3'd3;
      rec_new.st   = state;
    end else if (ev_pers) begin
      rec_new.code = 3'd4;
      rec_new.sidx = pers_idx;
      rec_new.st   = state;
    end else if (ev_stall) begin
      rec_new.code = 3'd5;
      rec_new.st   = state;
    end
  end

  // clr_err zeroes the base so a same-cycle violation lands on a clean record
  assign vc_base = clr_err ? '0 : viol_count;
  assign tc_base = clr_err ? '0 : trans_count;

  // ---------------- state tracking ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= SW'(INIT_STATE);
      primed    <= 1'b0;
      sig_prev  <= '0;
      stall_cnt <= '0;
    end else if (!arm) begin
      state     <= SW'(INIT_STATE);
      primed    <= 1'b0;
      stall_cnt <= '0;
    end else if (!primed) begin
      sig_prev  <= sig;
      primed    <= 1'b1;
    end else begin
      sig_prev <= sig;
      if (acc) state <= tbl_nxt[ent];
      if (any_chg)                             stall_cnt <= '0;
      else if (stall_cnt < SCW'(STALL_LIMIT))  stall_cnt <= stall_cnt + SCW'(1);
    end

  // ---------------- sticky flags, first-error record, counters ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_in      <= 1'b0;
      err_out     <= 1'b0;
      err_multi   <= 1'b0;
      err_pers    <= 1'b0;
      err_stall   <= 1'b0;
      pers_mask   <= '0;
      rec         <= '0;
      viol_count  <= '0;
      trans_count <= '0;
    end else begin
      err_in    <= (err_in    & ~clr_err) | ev_in;
      err_out   <= (err_out   & ~clr_err) | ev_out;
      err_multi <= (err_multi & ~clr_err) | ev_multi;
      err_pers  <= (err_pers  & ~clr_err) | ev_pers;
      err_stall <= (err_stall & ~clr_err) | ev_stall;
      pers_mask <= (pers_mask & ~{NSIG{clr_err}}) | pers_hit;
      if (clr_err || rec.code == 3'd0) rec <= rec_new;
      viol_count  <= (viol && vc_base != '1) ? vc_base + CNT_W'(1) : vc_base;
      trans_count <= (acc  && tc_base != '1) ? tc_base + CNT_W'(1) : tc_base;
    end

  assign first_code  = rec.code;
  assign first_sig   = rec.sidx;
  assign first_state = rec.st;
endmodule

// File: doc/sg_compliance_monitor.md
# sg_compliance_monitor

Parametrised, runtime-programmable state-graph compliance monitor for the synchronous model of an asynchronous circuit. It tracks the specification state from observed signal transitions and flags five conditions: input non-compliance, output non-compliance, concurrent transitions, output-persistency loss and stalls. It sits beside the circuit model in simulation and emulation, and takes the state graph as a loadable transition table rather than a per-spec generated module.

## Interface
- NSIG, 4: total monitored signals; indices 0..NIN-1 are inputs, NIN..NSIG-1 are stateful outputs/internals
- NIN, 2: number of input signals (1 ≤ NIN < NSIG)
- NSTATE, 8: number of spec states
- INIT_STATE, 0: state after reset and while disarmed
- STALL_LIMIT, 64: consecutive no-change checked cycles that raise err_stall
- CNT_W, 16: width of counters
- Derived: SW = clog2(NSTATE), IW = clog2(NSIG), AW = clog2(NSTATE*NSIG*2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- arm  in  1  1 = checking enabled; 0 = idle, table writable
- clr_err  in  1  pulse: clears sticky flags, first-error record, counters
- sig  in  NSIG  current captured signal values
- sig_precap  in  NSIG  pre-capture (next) values; bit differs from sig = transition enabled
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  entry index = (state*NSIG + sig_idx)*2 + dir (dir 1 = rise)
- cfg_data  in  SW+1  {valid, next_state}
- state  out  SW  current spec state
- err_in, err_out, err_multi, err_pers, err_stall  out  1 each  sticky flags
- pers_mask  out  NSIG  sticky per-signal persistency violation mask (input bits always 0)
- first_code  out  3  first error: 0 none, 1 in, 2 out, 3 multi, 4 pers, 5 stall
- first_sig  out  IW  signal index of first error (0 for multi/stall)
- first_state  out  SW  state at first error
- viol_count  out  CNT_W  saturating violation count
- trans_count  out  CNT_W  saturating accepted-transition count

## Operation
- Table: NSTATE*NSIG*2 entries of {valid, next}. Valid bits reset to 0; next fields are not reset. Writes take effect when cfg_we=1, arm=0 and cfg_addr < NSTATE*NSIG*2; all other writes are ignored. Table reads are combinational.
- Disarmed (arm=0): state = INIT_STATE, primed = 0, stall counter = 0; flags and counters hold.
- First armed cycle: sig_prev <= sig, primed <= 1, no checks.
- Each checked cycle (arm=1, primed=1), with chg = sig ^ sig_prev and sig_prev <= sig:
  - chg == 0: stall counter +1, saturating at STALL_LIMIT. Reaching STALL_LIMIT sets err_stall once per stall episode.
  - Exactly one bit i of chg set, dir = sig[i]: entry = table[state][i][dir].
    - valid: state <= next, trans_count +1.
    - invalid: state holds. Sets err_in if i < NIN, otherwise err_out.
  - More than one bit set: err_multi, state holds.
  - Any chg: stall counter <= 0.
- Persistency, for i ≥ NIN: ena_i = sig[i] ^ sig_precap[i], and ena_prev is registered each checked cycle. The condition ena_prev_i & ~ena_i & ~chg[i] sets err_pers and pers_mask[i].
- Every violation event increments viol_count by 1 per cycle, even if several flags fire in that cycle. When several flags fire in the same cycle, first_* records the lowest code, using the lowest index for pers. first_* is written only when first_code == 0.
- clr_err together with a violation in the same cycle: the new violation wins. Flags and first_* hold the new event and viol_count = 1.

## Timing
- All state updates are on the posedge of clk. Outputs are registered.
- Latency: a transition on sig at edge n updates state and flags at edge n+1.
- reset asserted, including mid-operation, gives immediately: state = INIT_STATE, primed = 0, all flags, masks, first_* and counters = 0, and all table valid bits = 0.
- Dropping arm mid-run returns state to INIT_STATE on the next edge. Re-arming repeats the priming cycle.

## Test plan
4-phase handshake, with NSIG=2, NIN=1, sig0=req, sig1=ack, and table 0 -req+-> 1 -ack+-> 2 -req−-> 3 -ack−-> 0.
- Program the 4 entries, arm, then drive req/ack through 3 full cycles, one edge at a time -> state sequence 0,1,2,3,0…; trans_count = 12; all flags 0.
- From state 0, raise ack -> err_out = 1, first_code = 2, first_sig = 1, first_state = 0, state stays 0, viol_count = 1.
- In state 1, toggle req and ack in the same cycle -> err_multi = 1, state stays 1.
- In state 1, sig_precap[1] = 1 for one cycle, then it returns to 0 while ack stays 0 -> err_pers = 1, pers_mask = 2'b10.
- Armed with no sig change for 64 cycles -> err_stall rises on the 64th checked cycle. Assert reset mid-run -> all outputs 0, state = 0, and a subsequent req+ gives err_in, because the table is cleared.
- cfg_we while arm=1 and an out-of-range cfg_addr -> table unchanged; verify by replaying the first scenario.
